// File: rtl/sparc_core_rtap_ctl_pkg.sv
// Shared types and constants for the per-core rtap debug request sequencer.
package sparc_core_rtap_ctl_pkg;

    // Sequencer states; encodings kept identical to the legacy localparams.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Source of the data presented on the response bus during RESP.
    typedef enum logic [1:0] {
        RSP_CLIENT = 2'd0,
        RSP_ZERO   = 2'd1,
        RSP_ONES   = 2'd2
    } rsp_kind_t;

    // Fill bit for the timeout response payload (all-ones data).
    localparam logic RTAP_TO_FILL = 1'b1;

    // Core-side debug client ID assignments on the rtap bus.
    typedef enum logic [3:0] {
        JTAG_CORE_ID_IFU_SSCAN = 4'd1,
        JTAG_CORE_ID_TLU_DBG   = 4'd2,
        JTAG_CORE_ID_LSU_DBG   = 4'd3,
        JTAG_CORE_ID_SPARE     = 4'd4
    } core_id_e;

endpackage

// File: rtl/sparc_core_rtap_ctl_if.sv
// rtap request/response bus plus the per-client request/response bus.
// master: the environment (rtap block and debug clients); slave: the sequencer.
interface sparc_core_rtap_ctl_if #(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned NUM_CLIENTS = 4
);
    logic                          rtap_core_val;
    logic [1:0]                    rtap_core_threadid;
    logic [ID_W-1:0]               rtap_core_id;
    logic [DATA_W-1:0]             rtap_core_data;
    logic [NUM_CLIENTS-1:0]        client_req_val;
    logic [1:0]                    client_req_threadid;
    logic [DATA_W-1:0]             client_req_data;
    logic [NUM_CLIENTS-1:0]        client_rsp_val;
    logic [NUM_CLIENTS*DATA_W-1:0] client_rsp_data;
    logic                          core_rtap_val;
    logic [DATA_W-1:0]             core_rtap_data;
    logic                          core_rtap_err;

    modport master (
        output rtap_core_val, rtap_core_threadid, rtap_core_id, rtap_core_data,
        output client_rsp_val, client_rsp_data,
        input  client_req_val, client_req_threadid, client_req_data,
        input  core_rtap_val, core_rtap_data, core_rtap_err
    );

    modport slave (
        input  rtap_core_val, rtap_core_threadid, rtap_core_id, rtap_core_data,
        input  client_rsp_val, client_rsp_data,
        output client_req_val, client_req_threadid, client_req_data,
        output core_rtap_val, core_rtap_data, core_rtap_err
    );
endinterface

// File: rtl/sparc_core_rtap_ctl_rspmux.sv
// Registered NUM_CLIENTS:1 select of the flattened client response data.
module sparc_core_rtap_rspmux #(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic                          rclk,
    input  logic                          arst_l,
    input  logic                          load,
    input  logic [IDX_W-1:0]              idx,
    input  logic [NUM_CLIENTS*DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0]             data
);

    // Capture the selected client's slice when the sequencer accepts its response.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            data <= '0;
        end else if (load) begin
            data <= rsp_data[idx*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/sparc_core_rtap_ctl.sv
// Per-core JTAG debug request sequencer: decodes the rtap core ID, strobes one
// client, waits for its response and returns it on the shared response bus.
// Optional response timeout enabled by defining SPARC_RTAP_CTL_TIMEOUT_EN.
module sparc_core_rtap_ctl
    import sparc_core_rtap_ctl_pkg::*;
#(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned BASE_ID     = JTAG_CORE_ID_IFU_SSCAN,
    parameter int unsigned TO_CYC      = 63
) (
    input  logic                  rclk,
    input  logic                  arst_l,
    sparc_core_rtap_ctl_if.slave  bus,
    output logic                  ctl_busy,
    output logic                  ctl_drop
);

    localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    state_t              state_q, state_d;
    rsp_kind_t           kind_q;
    logic [IDX_W-1:0]    idx_q;
    logic [1:0]          thread_q;
    logic [DATA_W-1:0]   payload_q;
    logic                got_q;
    logic                drop_q;
    logic [DATA_W-1:0]   mux_data;

    logic [ID_W-1:0]     id;
    logic [31:0]         id_ext;
    logic                in_range;
    logic                rsp_hit;
    logic                timeout_hit;
    logic                accept;
    logic                reject;
    logic                capture;
    logic                timeout;

    assign id       = bus.rtap_core_id;
    assign id_ext   = 32'(id);
    assign in_range = (id_ext >= BASE_ID) && (id_ext < BASE_ID + NUM_CLIENTS);
    assign rsp_hit  = bus.client_rsp_val[idx_q];

`ifdef SPARC_RTAP_CTL_TIMEOUT_EN
    logic [7:0] cnt_q;

    // Compare against the count including the current WAIT cycle, so the
    // timeout fires in the TO_CYC-th WAIT cycle.
    assign timeout_hit = ((32'(cnt_q) + 32'd1) == TO_CYC);

    // WAIT-cycle counter, zeroed on ISSUE.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            cnt_q <= '0;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and datapath control strobes.
    // A response seen during ISSUE is captured immediately and remembered in
    // got_q so WAIT can proceed to RESP without needing a second strobe.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rtap_core_val) begin
                    if (in_range) begin
                        accept  = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        reject  = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                capture = rsp_hit;
                state_d = WAIT;
            end
            WAIT: begin
                if (got_q || rsp_hit) begin
                    capture = rsp_hit && !got_q;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    timeout = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latches, response-source tracking and ISSUE-cycle response flag.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            idx_q     <= '0;
            thread_q  <= '0;
            payload_q <= '0;
            kind_q    <= RSP_CLIENT;
            got_q     <= 1'b0;
        end else begin
            if (accept) begin
                idx_q     <= IDX_W'(id_ext - BASE_ID);
                thread_q  <= bus.rtap_core_threadid;
                payload_q <= bus.rtap_core_data;
                kind_q    <= RSP_CLIENT;
            end
            if (reject) begin
                kind_q <= RSP_ZERO;
            end
            if (timeout) begin
                kind_q <= RSP_ONES;
            end
            if (state_q == ISSUE) begin
                got_q <= rsp_hit;
            end
        end
    end

    // Sticky record of requests arriving while a transaction is in flight.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            drop_q <= 1'b0;
        end else if (bus.rtap_core_val && (state_q != IDLE)) begin
            drop_q <= 1'b1;
        end
    end

    sparc_core_rtap_rspmux #(
        .DATA_W      (DATA_W),
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_rspmux (
        .rclk     (rclk),
        .arst_l   (arst_l),
        .load     (capture),
        .idx      (idx_q),
        .rsp_data (bus.client_rsp_data),
        .data     (mux_data)
    );

    // Output decode from registered state.
    always_comb begin
        bus.client_req_val      = '0;
        bus.client_req_threadid = thread_q;
        bus.client_req_data     = payload_q;
        bus.core_rtap_val       = 1'b0;
        bus.core_rtap_err       = 1'b0;
        bus.core_rtap_data      = '0;
        ctl_busy                = (state_q != IDLE);
        ctl_drop                = drop_q;
        if (state_q == ISSUE) begin
            bus.client_req_val[idx_q] = 1'b1;
        end
        if (state_q == RESP) begin
            bus.core_rtap_val = 1'b1;
            bus.core_rtap_err = (kind_q != RSP_CLIENT);
            unique case (kind_q)
                RSP_CLIENT: bus.core_rtap_data = mux_data;
                RSP_ONES:   bus.core_rtap_data = {DATA_W{RTAP_TO_FILL}};
                default:    bus.core_rtap_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sparc_core_rtap_ctl.sv
// Self-checking bench for sparc_core_rtap_ctl: directed test-plan steps plus
// randomized transactions checked cycle by cycle against a timing model.
module tb_sparc_core_rtap_ctl;

    localparam int DW = 128;
    localparam int NC = 4;
    localparam int BASE = 1;
    localparam int TO = 5;

    logic rclk = 1'b0;
    logic arst_l = 1'b0;
    logic ctl_busy;
    logic ctl_drop;

    int tests = 0;
    int fails = 0;
    logic exp_drop = 1'b0;

    sparc_core_rtap_ctl_if #(.DATA_W(DW), .ID_W(4), .NUM_CLIENTS(NC)) bus ();

    sparc_core_rtap_ctl #(
        .DATA_W      (DW),
        .ID_W        (4),
        .NUM_CLIENTS (NC),
        .BASE_ID     (BASE),
        .TO_CYC      (TO)
    ) dut (
        .rclk     (rclk),
        .arst_l   (arst_l),
        .bus      (bus),
        .ctl_busy (ctl_busy),
        .ctl_drop (ctl_drop)
    );

    always #5 rclk = ~rclk;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction: request in cycle 0, client answers d cycles after its
    // strobe (d<0: never), optional decoy response from another client and
    // optional extra request while busy. Outputs checked every cycle.
    task automatic run_txn(input logic [3:0] id, input logic [1:0] th, input logic [127:0] pay,
                           input int d, input logic [127:0] rdata,
                           input int decoy_c, input int decoy_cl, input logic [127:0] ddata,
                           input int drop_c);
        bit inr;
        bit timed_out;
        int idx;
        int rc;
        bit err;
        logic [127:0] edata;
        logic [3:0] onehot;
        int last;
        int dc;
        inr = (int'(id) >= BASE) && (int'(id) < BASE + NC);
        idx = int'(id) - BASE;
        onehot = inr ? 4'(1 << idx) : 4'b0;
        timed_out = 1'b0;
`ifdef SPARC_RTAP_CTL_TIMEOUT_EN
        timed_out = inr && ((d < 0) || (d > TO));
`endif
        if (!inr) begin
            rc = 1; err = 1'b1; edata = '0;
        end else if (timed_out) begin
            rc = 2 + TO; err = 1'b1; edata = '1;
        end else begin
            rc = 2 + ((d < 1) ? 1 : d); err = 1'b0; edata = rdata;
        end
        last = rc;
        if (inr && (1 + d > last)) last = 1 + d;
        if (decoy_c > last) last = decoy_c;
        if (drop_c > last) last = drop_c;
        last += 2;
        for (int c = 0; c <= last; c++) begin
            @(negedge rclk);
            if (drop_c > 0 && c == drop_c + 1) exp_drop = 1'b1;
            chk($sformatf("req_val c%0d", c), 128'(bus.client_req_val), 128'((c == 1) ? onehot : 4'b0));
            if (inr && c == 1) begin
                chk("req_thread", 128'(bus.client_req_threadid), 128'(th));
                chk("req_data", bus.client_req_data, pay);
            end
            chk($sformatf("rsp_val c%0d", c), 128'(bus.core_rtap_val), 128'(c == rc));
            chk($sformatf("rsp_err c%0d", c), 128'(bus.core_rtap_err), 128'((c == rc) && err));
            chk($sformatf("rsp_data c%0d", c), bus.core_rtap_data, (c == rc) ? edata : 128'd0);
            chk($sformatf("busy c%0d", c), 128'(ctl_busy), 128'((c >= 1) && (c <= rc)));
            chk($sformatf("drop c%0d", c), 128'(ctl_drop), 128'(exp_drop));
            // drive inputs for this cycle
            bus.rtap_core_val = 1'b0;
            bus.client_rsp_val = '0;
            bus.client_rsp_data = {rnd128(), rnd128(), rnd128(), rnd128()};
            if (c == 0) begin
                bus.rtap_core_val = 1'b1;
                bus.rtap_core_id = id;
                bus.rtap_core_threadid = th;
                bus.rtap_core_data = pay;
            end else if (c == drop_c) begin
                bus.rtap_core_val = 1'b1;
                bus.rtap_core_id = 4'($urandom_range(0, 15));
                bus.rtap_core_threadid = 2'($urandom);
                bus.rtap_core_data = rnd128();
            end
            if (inr && d >= 0 && c == 1 + d) begin
                bus.client_rsp_val[idx] = 1'b1;
                bus.client_rsp_data[idx*DW +: DW] = rdata;
            end
            if (c == decoy_c) begin
                if (decoy_cl >= 0) dc = decoy_cl;
                else if (inr) dc = (idx + 1 + int'($urandom_range(0, 2))) % NC;
                else dc = int'($urandom_range(0, NC - 1));
                bus.client_rsp_val[dc] = 1'b1;
                bus.client_rsp_data[dc*DW +: DW] = ddata;
            end
        end
    endtask

    initial begin
        bit inr;
        int d;
        logic [3:0] rid;
        bus.rtap_core_val = 1'b0;
        bus.rtap_core_threadid = '0;
        bus.rtap_core_id = '0;
        bus.rtap_core_data = '0;
        bus.client_rsp_val = '0;
        bus.client_rsp_data = '0;

        // reset state
        repeat (2) @(negedge rclk);
        chk("reset req_val", 128'(bus.client_req_val), 128'd0);
        chk("reset req_thread", 128'(bus.client_req_threadid), 128'd0);
        chk("reset req_data", bus.client_req_data, 128'd0);
        chk("reset rsp_val", 128'(bus.core_rtap_val), 128'd0);
        chk("reset rsp_data", bus.core_rtap_data, 128'd0);
        chk("reset busy", 128'(ctl_busy), 128'd0);
        chk("reset drop", 128'(ctl_drop), 128'd0);
        arst_l = 1'b1;

        // 1: client 1, answer 2 cycles after strobe
        run_txn(4'd2, 2'd1, 128'hA5, 2, 128'h1234, -1, -1, '0, -1);
        // 2: unmapped ID
        run_txn(4'hF, 2'd3, 128'h77, 0, '0, -1, -1, '0, -1);
        run_txn(4'h0, 2'd0, 128'h55, 0, '0, 1, -1, 128'hBAD, -1);
        // response in the ISSUE cycle, and in the first WAIT cycle
        run_txn(4'd4, 2'd2, rnd128(), 0, rnd128(), -1, -1, '0, -1);
        run_txn(4'd1, 2'd0, rnd128(), 1, rnd128(), -1, -1, '0, -1);
        // 4: client 2 active, client 0 decoy
        run_txn(4'd3, 2'd2, 128'h9, 3, 128'hBEEF, 2, 0, 128'hDEAD, -1);
`ifdef SPARC_RTAP_CTL_TIMEOUT_EN
        // 5: timeout with no response, then response exactly on the limit
        run_txn(4'd2, 2'd1, 128'h3C, -1, '0, -1, -1, '0, -1);
        run_txn(4'd2, 2'd1, 128'h3C, TO, 128'hC0FFEE, -1, -1, '0, -1);
        run_txn(4'd4, 2'd0, 128'h1, TO + 1, 128'h5A5A, -1, -1, '0, -1);
`endif

        // randomized, no drops
        for (int n = 0; n < 30; n++) begin
            rid = 4'($urandom_range(0, 15));
`ifdef SPARC_RTAP_CTL_TIMEOUT_EN
            d = int'($urandom_range(0, 8)) - 1;
`else
            d = int'($urandom_range(0, 7));
`endif
            run_txn(rid, 2'($urandom), rnd128(), d, rnd128(),
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 6)) : -1, -1, rnd128(), -1);
        end

        // 3: extra request during WAIT is dropped, flag sticks
        run_txn(4'd1, 2'd3, 128'hF00D, 3, 128'h4321, -1, -1, '0, 2);

        // randomized with drops
        for (int n = 0; n < 20; n++) begin
            rid = 4'($urandom_range(0, 15));
            inr = (int'(rid) >= BASE) && (int'(rid) < BASE + NC);
            d = int'($urandom_range(0, 5));
            run_txn(rid, 2'($urandom), rnd128(), d, rnd128(),
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 6)) : -1, -1, rnd128(),
                    inr ? int'($urandom_range(1, 3)) : 1);
        end

        // 6: reset during WAIT, late response ignored
        @(negedge rclk);
        bus.rtap_core_val = 1'b1;
        bus.rtap_core_id = 4'd2;
        bus.rtap_core_data = rnd128();
        @(negedge rclk);
        bus.rtap_core_val = 1'b0;
        @(negedge rclk);
        chk("pre-reset busy", 128'(ctl_busy), 128'd1);
        arst_l = 1'b0;
        exp_drop = 1'b0;
        #1;
        chk("mid-reset busy", 128'(ctl_busy), 128'd0);
        chk("mid-reset drop", 128'(ctl_drop), 128'd0);
        chk("mid-reset req_data", bus.client_req_data, 128'd0);
        @(negedge rclk);
        arst_l = 1'b1;
        bus.client_rsp_val = 4'b0010;
        bus.client_rsp_data[1*DW +: DW] = 128'hFEED;
        for (int c = 0; c < 4; c++) begin
            @(negedge rclk);
            bus.client_rsp_val = '0;
            chk($sformatf("post-reset rsp_val c%0d", c), 128'(bus.core_rtap_val), 128'd0);
            chk($sformatf("post-reset rsp_data c%0d", c), bus.core_rtap_data, 128'd0);
            chk($sformatf("post-reset busy c%0d", c), 128'(ctl_busy), 128'd0);
            chk($sformatf("post-reset drop c%0d", c), 128'(ctl_drop), 128'd0);
            chk($sformatf("post-reset req_val c%0d", c), 128'(bus.client_req_val), 128'd0);
        end

        // normal operation after reset
        run_txn(4'd4, 2'd2, rnd128(), 2, rnd128(), -1, -1, '0, -1);
        run_txn(4'd9, 2'd1, rnd128(), 0, '0, -1, -1, '0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sparc_core_rtap_ctl.md
Name: sparc_core_rtap_ctl

Overview:
Per-core JTAG debug request sequencer. It sits between the rtap request bus and the core-side debug sources (IFU shadow-scan snapshot, TLU/LSU debug readers, and so on). It decodes the rtap core ID, issues a one-cycle request to exactly one client, waits for that client's response, and returns the data on a single shared response bus. Only one transaction is ever outstanding.

Parameters:
DATA_W, 128, width of the rtap request/response data bus (matches `CORE_JTAG_BUS_WIDTH).
ID_W, 4, width of the rtap core ID (matches `JTAG_CORE_ID_WIDTH).
NUM_CLIENTS, 4, number of debug clients; client i owns ID BASE_ID+i.
BASE_ID, 1, first ID owned by this controller.
TO_CYC, 63, response timeout in cycles; must be ≥1 and < 2^8.

Ports:
rclk  in  1  core clock.
arst_l  in  1  asynchronous active-low reset.
rtap_core_val  in  1  request valid, single-cycle pulse.
rtap_core_threadid  in  2  target thread.
rtap_core_id  in  ID_W  target client ID.
rtap_core_data  in  DATA_W  request payload.
client_req_val  out  NUM_CLIENTS  one-hot, single-cycle request strobe.
client_req_threadid  out  2  registered thread ID for the active request.
client_req_data  out  DATA_W  registered payload for the active request.
client_rsp_val  in  NUM_CLIENTS  per-client response strobe.
client_rsp_data  in  NUM_CLIENTS*DATA_W  flattened; client i occupies bits [i*DATA_W +: DATA_W].
core_rtap_val  out  1  response valid, single-cycle.
core_rtap_data  out  DATA_W  response data; zero whenever core_rtap_val=0.
core_rtap_err  out  1  qualifies core_rtap_val: unknown ID or timeout.
ctl_busy  out  1  high in every state except IDLE.
ctl_drop  out  1  sticky flag: a request arrived while busy; cleared only by reset.

Behaviour:
- Reset (arst_l=0, asynchronous): state=IDLE; all outputs 0; timeout counter, latched index/thread/payload and ctl_drop all cleared.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - rtap_core_val with an ID in [BASE_ID, BASE_ID+NUM_CLIENTS-1] → latch idx=ID-BASE_ID, thread and payload; go to ISSUE.
  - rtap_core_val with an out-of-range ID → go to RESP with err=1 and data=0. No client is strobed.
- ISSUE: client_req_val[idx]=1 for exactly this cycle; counter=0; go to WAIT.
- WAIT:
  - Only client_rsp_val[idx] is honoured; responses from any other client are ignored.
  - When client_rsp_val[idx]=1, register its data slice; go to RESP with err=0.
  - A response arriving in the same cycle as ISSUE is also captured.
- RESP: core_rtap_val=1 with the registered data and err for one cycle; return to IDLE.
- Total latency: in-range request to core_rtap_val is 3 cycles minimum (rsp in ISSUE cycle); unknown-ID request to core_rtap_val is 1 cycle.
- A new rtap_core_val in the same cycle as RESP is dropped. Any rtap_core_val while state≠IDLE is dropped and sets ctl_drop.
- Back-to-back requests: the earliest acceptance of the next request is the IDLE cycle after RESP.
- Reset asserted mid-transaction: the transaction is abandoned with no response. A late client response after reset is ignored because the state is IDLE.

Optional Feature:
SPARC_RTAP_CTL_TIMEOUT_EN.
- Defined: an 8-bit counter increments in each WAIT cycle. When counter==TO_CYC with no response, go to RESP with err=1 and data all-ones. A response arriving in that same cycle wins (err=0).
- Undefined: the counter logic is absent and WAIT persists until a response or reset.

Decomposition:
- Shared package/header: state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3), the all-ones timeout data constant, and the core-ID assignments including `JTAG_CORE_ID_IFU_SSCAN.
- Sub-module: sparc_core_rtap_rspmux, a registered NUM_CLIENTS:1 data select by idx. It keeps the flattened slicing out of the FSM.

Test Plan:
1. Reset then ID=BASE_ID+1, data=0xA5; client 1 responds 2 cycles after its strobe with 0x1234 → client_req_val=4'b0010 pulsed once; core_rtap_val 1 cycle with data=0x1234, err=0.
2. ID=0xF (unmapped) → core_rtap_val on the next cycle with err=1, data=0; no client_req_val.
3. Second request issued during WAIT → ignored; ctl_drop=1 and stays 1; the first response completes normally.
4. Client 2 active; client 0 pulses rsp_val with 0xDEAD → ignored; the later client 2 response (0xBEEF) is returned.
5. TIMEOUT_EN, TO_CYC=5, no response → core_rtap_val 5 WAIT cycles after ISSUE with err=1, data all-ones. Repeat with a response exactly at cycle 5 → err=0 with the client data.
6. arst_l pulsed low during WAIT, then the client responds → no core_rtap_val; state IDLE; ctl_busy=0; ctl_drop=0.
